downscale_stream: RTL and testbench

//  Parametrised successor to the softmax max-subtract stage. Accepts one vector Z of up to MAX_LEN

---
 rtl/downscale_stream_pkg.sv | 15 +
 rtl/downscale_buf.sv | 38 +++
 rtl/downscale_stream.sv | 152 +++++++++++++++
 tb/tb_downscale_stream.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/downscale_stream_pkg.sv
// Shared definitions for the softmax max-subtract stage: FSM states and default sizes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package downscale_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_MAX_LEN = 16;

endpackage

// File: rtl/downscale_buf.sv
// Vector buffer: DEPTH x DATA_W register file, one write port, one registered read port.
// Latency: read data appears the cycle after the address; a same-cycle write is forwarded.
// Backpressure: none; the caller holds the read address to hold the read data.
module downscale_buf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array; contents are left untouched by reset.
    always_ff @(posedge clock_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Registered read; forward the write so a 1-beat vector is readable right away.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rd_dat <= '0;
        end else if (wr_en && (wr_addr == rd_addr)) begin
            rd_dat <= wr_dat;
        end else begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/downscale_stream.sv
// Buffers one logit vector while tracking its signed max, then replays Zi - Zmax.
// Latency: first output beat the cycle after the last input beat is accepted.
// Backpressure: output index holds while out_ready_i is low; no input is accepted during replay.
module downscale_stream
    import downscale_stream_pkg::*;
#(
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int MAX_LEN = DEF_MAX_LEN,
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W:0]   out_data_o,
    output logic              out_last_o,
    output logic [DATA_W-1:0] max_o,
    output logic              err_len_o
);

    localparam int ADDR_W = $clog2(MAX_LEN);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, len_q, n_q;
    logic [CNT_W-1:0]          cnt_nxt, len_eff;
    logic signed [DATA_W-1:0]  max_q;
    logic                      in_rdy_q;
    logic                      accept, vec_end, len_hit, emit_hs, emit_last;
    logic [ADDR_W-1:0]         rd_addr;
    logic [DATA_W-1:0]         rd_dat;
    logic [DATA_W:0]           diff;

    assign cnt_nxt   = cnt_q + CNT_W'(1);
    assign len_eff   = ((len_i == '0) || (len_i > CNT_W'(MAX_LEN))) ? CNT_W'(MAX_LEN) : len_i;
    assign emit_hs   = (state_q == ST_EMIT) && out_ready_i;
    assign emit_last = (cnt_q == n_q - CNT_W'(1));

    // State register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, input acceptance, vector-end detection and length-mismatch flag.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        vec_end   = 1'b0;
        len_hit   = 1'b0;
        err_len_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                accept  = in_valid_i && in_rdy_q;
                len_hit = (len_eff == CNT_W'(1));
                if (accept) begin
                    vec_end   = len_hit || in_last_i;
                    err_len_o = vec_end && (len_hit != in_last_i);
                    state_d   = vec_end ? ST_EMIT : ST_LOAD;
                end
            end
            ST_LOAD: begin
                accept  = in_valid_i && in_rdy_q;
                len_hit = (cnt_nxt == len_q);
                if (accept) begin
                    vec_end   = len_hit || in_last_i;
                    err_len_o = vec_end && (len_hit != in_last_i);
                    if (vec_end) begin
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (emit_hs && emit_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read address: hold the current index while stalled, look ahead on a handshake.
    always_comb begin
        rd_addr = '0;
        if (state_q == ST_EMIT) begin
            if (emit_hs && !emit_last) begin
                rd_addr = cnt_nxt[ADDR_W-1:0];
            end else if (!emit_hs) begin
                rd_addr = cnt_q[ADDR_W-1:0];
            end
        end
    end

    // Counters, latched length, running max and registered input ready.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            len_q    <= '0;
            n_q      <= '0;
            max_q    <= '0;
            in_rdy_q <= 1'b0;
        end else begin
            in_rdy_q <= (state_d != ST_EMIT);
            if (accept) begin
                if (state_q == ST_IDLE) begin
                    len_q <= len_eff;
                    max_q <= $signed(in_data_i);
                end else if ($signed(in_data_i) > max_q) begin
                    max_q <= $signed(in_data_i);
                end
                if (vec_end) begin
                    cnt_q <= '0;
                    n_q   <= cnt_nxt;
                end else begin
                    cnt_q <= cnt_nxt;
                end
            end else if (emit_hs) begin
                cnt_q <= emit_last ? '0 : cnt_nxt;
            end
        end
    end

    downscale_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .wr_en   (accept),
        .wr_addr (cnt_q[ADDR_W-1:0]),
        .wr_dat  (in_data_i),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    // One extra bit makes the difference exact: worst case is -(2^DATA_W - 1).
    assign diff        = {rd_dat[DATA_W-1], rd_dat} - {max_q[DATA_W-1], max_q};
    assign out_valid_o = (state_q == ST_EMIT);
    assign out_last_o  = out_valid_o && emit_last;
    assign out_data_o  = out_valid_o ? diff : '0;
    assign max_o       = max_q;
    assign in_ready_o  = in_rdy_q;

endmodule

// File: tb/tb_downscale_stream.sv
module tb_downscale_stream;

    localparam int DW = 16;
    localparam int ML = 16;
    localparam int CW = 5;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic [CW-1:0] len_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          in_last_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW:0]   out_data_o;
    logic          out_last_o;
    logic [DW-1:0] max_o;
    logic          err_len_o;

    downscale_stream #(.DATA_W(DW), .MAX_LEN(ML)) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .len_i       (len_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .max_o       (max_o),
        .err_len_o   (err_len_o)
    );

    always #5 clock_i = ~clock_i;

    int checks   = 0;
    int failures = 0;

    // Expected output beats, filled by the model when a vector is sent.
    int exp_dat_q[$];
    int exp_last_q[$];
    int exp_max_q[$];
    int got_q[$];
    int err_pulses = 0;
    int rdy_mode   = 0;

    bit          prev_stall = 1'b0;
    logic [DW:0] prev_dat;
    logic        prev_last;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: always on, or a coin flip each cycle.
    always @(posedge clock_i) begin
        #1;
        out_ready_i = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: every output handshake against the model, plus stall and ready rules.
    always @(negedge clock_i) begin
        if (reset_i) begin
            prev_stall = 1'b0;
        end else begin
            if (err_len_o) err_pulses++;
            if (out_valid_o) chk("in_ready_low_in_emit", int'(in_ready_o), 0);
            if (prev_stall) begin
                chk("stall_valid_held", int'(out_valid_o), 1);
                chk("stall_data_held", int'(out_data_o), int'(prev_dat));
                chk("stall_last_held", int'(out_last_o), int'(prev_last));
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_dat_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    chk("out_data", int'($signed(out_data_o)), exp_dat_q.pop_front());
                    chk("out_last", int'(out_last_o), exp_last_q.pop_front());
                    chk("max_o", int'($signed(max_o)), exp_max_q.pop_front());
                end
                got_q.push_back(int'($signed(out_data_o)));
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_dat   = out_data_o;
            prev_last  = out_last_o;
        end
    end

    // Model the vector from the length rules, then drive it beat by beat.
    task automatic send_vec(input int len, input int vals[16], input int last_pos);
        int eff, n, mx, exp_err, err0, t;
        eff = (len == 0 || len > ML) ? ML : len;
        n   = eff;
        if (last_pos >= 0 && last_pos + 1 < eff) n = last_pos + 1;
        exp_err = ((last_pos == n - 1) != (n == eff)) ? 1 : 0;
        mx = vals[0];
        for (int k = 1; k < n; k++) if (vals[k] > mx) mx = vals[k];
        for (int k = 0; k < n; k++) begin
            exp_dat_q.push_back(vals[k] - mx);
            exp_last_q.push_back((k == n - 1) ? 1 : 0);
            exp_max_q.push_back(mx);
        end
        err0 = err_pulses;
        for (int k = 0; k < n; k++) begin
            in_valid_i = 1'b1;
            in_data_i  = DW'(vals[k]);
            in_last_i  = (k == last_pos);
            len_i      = CW'(len);
            t = 0;
            while (!in_ready_o && t < 500) begin
                @(posedge clock_i); #1;
                t++;
            end
            if (t >= 500) begin
                chk("in_ready_timeout", 0, 1);
                break;
            end
            @(posedge clock_i); #1;
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        chk("first_out_valid_latency", int'(out_valid_o), 1);
        chk("err_len_pulses", err_pulses - err0, exp_err);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_dat_q.size() > 0 && t < 2000) begin
            @(posedge clock_i); #1;
            t++;
        end
        if (t >= 2000) chk("drain_timeout", 0, 1);
        @(posedge clock_i); #1;
    endtask

    initial begin
        int v[16];
        int t;
        reset_i     = 1'b1;
        len_i       = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b1;

        // Reset values.
        #12;
        chk("rst_in_ready", int'(in_ready_o), 0);
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_out_data", int'(out_data_o), 0);
        chk("rst_out_last", int'(out_last_o), 0);
        chk("rst_max", int'(max_o), 0);
        chk("rst_err", int'(err_len_o), 0);
        @(posedge clock_i); #2;
        reset_i = 1'b0;
        @(posedge clock_i); #1;
        chk("idle_in_ready", int'(in_ready_o), 1);

        // 1: mixed signs, max 0x0400.
        v = '{default: 0};
        v[0] = 'h0100; v[1] = 'h0400; v[2] = -'h0200; v[3] = 'h0050; v[4] = -'h0400;
        v[5] = 0;      v[6] = 'h03FF; v[7] = -'h7000; v[8] = 'h0123; v[9] = 'h0300;
        got_q.delete();
        send_vec(10, v, 9);
        drain();
        chk("t1_count", got_q.size(), 10);
        chk("t1_beat0", got_q[0], -768);
        chk("t1_beat9", got_q[9], -256);
        chk("t1_max_held", int'(max_o), 'h0400);
        chk("t1_idle_ready", int'(in_ready_o), 1);

        // 2: all negative.
        v = '{default: 0};
        v[0] = -5; v[1] = -1; v[2] = -9; v[3] = -3;
        got_q.delete();
        send_vec(4, v, 3);
        drain();
        chk("t2_b0", got_q[0], -4);
        chk("t2_b1", got_q[1], 0);
        chk("t2_b2", got_q[2], -8);
        chk("t2_b3", got_q[3], -2);

        // 3: full-range extremes.
        v = '{default: 0};
        v[0] = -32768; v[1] = 32767;
        got_q.delete();
        send_vec(2, v, 1);
        drain();
        chk("t3_b0", got_q[0], -65535);
        chk("t3_b1", got_q[1], 0);

        // 4: random backpressure, 16-beat vector then back-to-back vector with ties.
        rdy_mode = 1;
        for (int k = 0; k < 16; k++) v[k] = $urandom_range(0, 65535) - 32768;
        got_q.delete();
        send_vec(16, v, 15);
        v = '{default: 0};
        v[0] = 7; v[1] = 7; v[2] = -2;
        send_vec(3, v, 2);
        drain();
        rdy_mode = 0;
        chk("t4_count", got_q.size(), 19);
        chk("t4_tie0", got_q[16], 0);
        chk("t4_tie1", got_q[17], 0);
        chk("t4_tie2", got_q[18], -9);

        // 5: length rules.
        for (int k = 0; k < 16; k++) v[k] = k * 37 - 200;
        got_q.delete();
        send_vec(8, v, 4);
        drain();
        chk("t5_early_count", got_q.size(), 5);
        got_q.delete();
        send_vec(0, v, 15);
        drain();
        chk("t5_len0_count", got_q.size(), 16);
        got_q.delete();
        send_vec(3, v, -1);
        drain();
        chk("t5_nolast_count", got_q.size(), 3);
        got_q.delete();
        send_vec(20, v, 15);
        drain();
        chk("t5_over_count", got_q.size(), 16);

        // 6: reset in the middle of replay.
        for (int k = 0; k < 16; k++) v[k] = 100 - k * 11;
        got_q.delete();
        send_vec(8, v, 7);
        t = 0;
        while (got_q.size() < 3 && t < 100) begin
            @(negedge clock_i);
            t++;
        end
        if (t >= 100) chk("t6_wait_timeout", 0, 1);
        @(posedge clock_i); #2;
        reset_i = 1'b1;
        #1;
        chk("t6_rst_valid", int'(out_valid_o), 0);
        chk("t6_rst_data", int'(out_data_o), 0);
        chk("t6_rst_last", int'(out_last_o), 0);
        chk("t6_rst_max", int'(max_o), 0);
        chk("t6_rst_ready", int'(in_ready_o), 0);
        exp_dat_q.delete();
        exp_last_q.delete();
        exp_max_q.delete();
        repeat (2) @(posedge clock_i);
        #2;
        reset_i = 1'b0;
        @(posedge clock_i); #1;
        v = '{default: 0};
        v[0] = 3; v[1] = 1; v[2] = 2;
        got_q.delete();
        send_vec(3, v, 2);
        drain();
        chk("t6_after_count", got_q.size(), 3);
        chk("t6_after_b1", got_q[1], -2);
        chk("t6_after_b2", got_q[2], -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
